memb_skew_feeder: RTL and testbench
===================================

Name: memb_skew_feeder

Overview:
- Parametrised B-operand feeder for the systolic MAC array. It is the successor to the fixed-depth per-column FIFO feeder.
- Accepts one B row (DIM signed elements) per cycle under a valid/ready handshake and emits it skewed: column i is delayed i cycles relative to column 0.
- Column 0 has a fixed one-cycle latency.
- Injects zeros automatically on idle cycles and during drain, so the parent never has to feed padding.
- Tracks the rows of one matrix, drains the skew pipeline, and reports completion.

Parameters:
- BITS_AB, 8, element width (signed two's complement).
- DIM, 8, channel (column) count and skew depth; legal range 1..64.
- NROWS, DIM, maximum rows per matrix; legal range 1..1024.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  a row is presented on Bin.
- in_ready  out  1  the block can accept a row this cycle.
- in_last  in  1  qualifies an accepted row as the final row of the matrix (early termination).
- Bin  in  [DIM-1:0][BITS_AB-1:0] signed  input row; Bin[i] feeds column i.
- Bout  out  [DIM-1:0][BITS_AB-1:0] signed  skewed output to the array's B edge.
- out_valid  out  [DIM-1:0]  Bout[i] carries real data (not injected zero).
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse while the last row's element is on Bout[DIM-1].

Behaviour:
- Reset: the edge with rst=1 forces the following.
  - State to IDLE; row counter to 0.
  - Every shift stage data to 0; every valid tag and last tag to 0.
  - Resulting outputs: Bout all 0, out_valid 0, done 0, busy 0, in_ready 1 from the next cycle.
  - Reset mid-operation discards all in-flight rows. No done is issued for them.
- Accept: accept = in_valid & in_ready. Bin is ignored when accept=0.
- Channel i is a shift register of i+1 stages that advances every cycle, with no enable.
  - Stage 0 loads Bin[i] with valid=1 on accept; otherwise it loads 0 with valid=0.
  - Bout[i] and out_valid[i] are the last stage of channel i.
- Timing: a row accepted on edge k drives Bout[i] with Bin[i] during the cycle after edge k+i.
  - Column 0 therefore has 1-cycle latency.
  - Column DIM-1 appears DIM-1 cycles after column 0.
- Channel DIM-1 carries an extra last tag, set on an accept that ends the matrix. done = that tag at the output stage.
- State machine:
  - IDLE: in_ready=1. An accept goes to LOAD with counter=1. If that accept also ends the matrix (in_last=1 or NROWS=1), go directly to FLUSH and set the last tag.
  - LOAD: in_ready=1. Each accept increments the counter. An accept with in_last=1 or counter==NROWS-1 sets the last tag and goes to FLUSH. Cycles without in_valid insert zero bubbles; skew is preserved.
  - FLUSH: in_ready=0, and zeros are injected. Leaves for IDLE on the edge ending the cycle in which done=1.
- busy = (state != IDLE).
- The counter is wide enough for NROWS and never wraps. Rows beyond NROWS cannot be accepted because FLUSH blocks them.
- Edge cases:
  - in_last is ignored when accept=0.
  - DIM=1: done coincides with Bout[0] of the last row, 1 cycle after the accept.
  - A new matrix is accepted no earlier than the cycle after done.
- No arithmetic is performed. Data passes bit-exact, sign preserved.

Test Plan:
1. Reset mid-FLUSH (DIM=4): rst high for 1 cycle -> next cycle Bout=0, out_valid=0, busy=0, in_ready=1, and no done pulse appears afterwards.
2. Single row, DIM=4, NROWS=4: accept Bin={4,3,2,1} with in_last=1 at edge k -> checks:
   - Bout[0]=1 after edge k; Bout[1]=2 after k+1; Bout[2]=3 after k+2; Bout[3]=4 after k+3.
   - done=1 only in that last cycle; out_valid otherwise 0.
3. Full matrix, back-to-back, DIM=4, NROWS=4: rows r*10+c for r=0..3 on 4 consecutive edges, then in_valid held high -> checks:
   - in_ready drops the cycle after the 4th accept.
   - Bout[3] shows 3,13,23,33 on consecutive cycles.
   - done is high with 33; in_ready returns to 1 the cycle after done.
4. Bubbles: rows A, gap, B with in_valid=0 on the gap -> each column shows A, 0 (out_valid=0), B, shifted by its own skew.
5. Signed extremes, BITS_AB=8: Bin={-128,127,-1,0} -> identical values out, no sign corruption, out_valid=1 on each.
6. Early termination: NROWS=4, accept 2 rows with in_last on the 2nd -> done with row 1 on Bout[3]; counter restarts at 0 for the next matrix.

Source files
------------

// File: rtl/memb_skew_feeder_if.sv
// Handshake and data bundle between the parent and the B-operand skew feeder.
//   in_valid/in_ready/in_last : row handshake, in_last marks the final row of a matrix
//   Bin                       : input row, Bin[i] feeds column i
//   Bout/out_valid            : skewed output row and per-column real-data flags
//   busy/done                 : feeder not idle / last row leaving column DIM-1
interface memb_skew_feeder_if #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned DIM     = 8
);
  logic                              in_valid;
  logic                              in_ready;
  logic                              in_last;
  logic signed [DIM-1:0][BITS_AB-1:0] Bin;
  logic signed [DIM-1:0][BITS_AB-1:0] Bout;
  logic        [DIM-1:0]              out_valid;
  logic                              busy;
  logic                              done;

  // Parent side
  modport master (
    output in_valid, in_last, Bin,
    input  in_ready, Bout, out_valid, busy, done
  );

  // Feeder side
  modport slave (
    input  in_valid, in_last, Bin,
    output in_ready, Bout, out_valid, busy, done
  );
endinterface

// File: rtl/memb_skew_feeder.sv
// Skewed B-operand feeder for the systolic MAC array.
// Accepts one row per cycle and delays column i by i cycles (column 0 has one
// cycle of latency). Idle and drain cycles shift in zeros. A last tag travels
// with column DIM-1 so that done fires when the matrix's final element leaves.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, discards all in-flight rows
//   bus  : feeder side of memb_skew_feeder_if
module memb_skew_feeder #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned DIM     = 8,
  parameter int unsigned NROWS   = DIM
) (
  input  logic                 clk,
  input  logic                 rst,
  memb_skew_feeder_if.slave    bus
);

  localparam int unsigned CW      = $clog2(NROWS + 1);
  localparam bit          ONE_ROW = (NROWS == 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          set_last;
  logic          accept;
  logic          ready_q;
  logic          busy_q;
  logic [DIM-1:0] lst;

  assign accept       = bus.in_valid & ready_q;
  assign bus.in_ready = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = lst[DIM-1];

  // State register; ready and busy are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ready_q <= (state_n != FLUSH);
      busy_q  <= (state_n != IDLE);
    end
  end

  // Next-state and row counting
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    set_last = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_n = CW'(1);
          if (bus.in_last || ONE_ROW) begin
            set_last = 1'b1;
            state_n  = FLUSH;
          end else begin
            state_n  = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          cnt_n = cnt + CW'(1);
          if (bus.in_last || (cnt == CW'(NROWS - 1))) begin
            set_last = 1'b1;
            state_n  = FLUSH;
          end
        end
      end
      FLUSH: begin
        // Leave once the final element is on the last column
        if (lst[DIM-1]) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Last-tag chain aligned with column DIM-1
  always_ff @(posedge clk) begin
    if (rst) begin
      lst <= '0;
    end else begin
      lst[0] <= set_last;
      for (int j = 1; j < int'(DIM); j++) begin
        lst[j] <= lst[j-1];
      end
    end
  end

  // Per-column shift registers: column i has i+1 free-running stages
  for (genvar i = 0; i < int'(DIM); i++) begin : g_ch
    logic [BITS_AB-1:0] dat [i+1];
    logic [i:0]         vld;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) begin
          dat[j] <= '0;
        end
        vld <= '0;
      end else begin
        dat[0] <= accept ? bus.Bin[i] : '0;
        vld[0] <= accept;
        for (int j = 1; j <= i; j++) begin
          dat[j] <= dat[j-1];
          vld[j] <= vld[j-1];
        end
      end
    end

    assign bus.Bout[i]      = dat[i];
    assign bus.out_valid[i] = vld[i];
  end

endmodule

// File: tb/tb_memb_skew_feeder.sv
// Randomized and directed bench for memb_skew_feeder (DIM=4, NROWS=4, 8-bit).
// The reference model keeps a history of accepted rows: column i at any cycle
// shows the row accepted i edges earlier, and matrix bookkeeping is counted
// in plain integers.
module tb_memb_skew_feeder;

  localparam int unsigned W     = 8;
  localparam int unsigned DIM   = 4;
  localparam int unsigned NROWS = 4;

  typedef logic [DIM-1:0][W-1:0] row_t;
  typedef struct packed {
    logic v;
    logic e;
    row_t row;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  memb_skew_feeder_if #(.BITS_AB(W), .DIM(DIM)) bus ();

  memb_skew_feeder #(.BITS_AB(W), .DIM(DIM), .NROWS(NROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  ent_t hist [DIM];
  bit   flushing = 1'b0;
  int   rows = 0;
  bit   cur_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, update model on the edge, then compare away from the edge
  task automatic cycle(input bit r, input bit v, input bit l, input row_t row);
    bit   acc;
    bit   ends;
    row_t eb;
    logic [DIM-1:0] ev;
    rst          = r;
    bus.in_valid = v;
    bus.in_last  = l;
    bus.Bin      = row;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < int'(DIM); i++) hist[i] = '0;
      flushing = 1'b0;
      rows     = 0;
      cur_done = 1'b0;
    end else begin
      acc = v && !flushing;
      if (flushing && cur_done) begin
        flushing = 1'b0;
        rows     = 0;
      end
      ends = 1'b0;
      if (acc) begin
        rows++;
        ends = l || (rows == int'(NROWS));
        if (ends) flushing = 1'b1;
      end
      for (int i = int'(DIM) - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = acc ? '{v: 1'b1, e: ends, row: row} : '0;
      cur_done = hist[DIM-1].v && hist[DIM-1].e;
    end
    for (int i = 0; i < int'(DIM); i++) begin
      eb[i] = hist[i].v ? hist[i].row[i] : '0;
      ev[i] = hist[i].v;
    end
    #1;
    check("bout",      64'(bus.Bout),      64'(eb));
    check("out_valid", 64'(bus.out_valid), 64'(ev));
    check("done",      64'(bus.done),      64'(cur_done));
    check("busy",      64'(bus.busy),      64'(flushing || rows != 0));
    check("in_ready",  64'(bus.in_ready),  64'(!flushing));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'($urandom), row_t'({$urandom, $urandom}));
  endtask

  function automatic row_t mk_row(input int r);
    row_t x;
    for (int c = 0; c < int'(DIM); c++) x[c] = W'(r * 10 + c);
    return x;
  endfunction

  initial begin
    row_t rw;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.Bin      = '0;

    // Reset and quiet start
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, mk_row(7));
    idle(2);

    // Single row with in_last
    rw = '{8'd4, 8'd3, 8'd2, 8'd1};
    cycle(1'b0, 1'b1, 1'b1, rw);
    idle(6);

    // Full matrix back-to-back with in_valid held high
    for (int r = 0; r < 10; r++) cycle(1'b0, 1'b1, 1'b0, mk_row(r < 4 ? r : 50 + r));
    idle(4);

    // Bubble between two rows
    cycle(1'b0, 1'b1, 1'b0, mk_row(11));
    cycle(1'b0, 1'b0, 1'b1, mk_row(99));
    cycle(1'b0, 1'b1, 1'b1, mk_row(22));
    idle(6);

    // Signed extremes
    rw = '{8'h80, 8'h7f, 8'hff, 8'h00};
    cycle(1'b0, 1'b1, 1'b1, rw);
    idle(5);

    // Early termination then a fresh matrix
    cycle(1'b0, 1'b1, 1'b0, mk_row(1));
    cycle(1'b0, 1'b1, 1'b1, mk_row(2));
    idle(5);
    for (int r = 0; r < 4; r++) cycle(1'b0, 1'b1, 1'b0, mk_row(r + 3));
    idle(5);

    // Reset while flushing: no done afterwards
    for (int r = 0; r < 4; r++) cycle(1'b0, 1'b1, 1'b0, mk_row(r + 6));
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    idle(6);

    // Random traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 99) < 70),
            ($urandom_range(0, 99) < 15),
            row_t'({$urandom, $urandom}));
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
